// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage core: load-use stalls, multi-cycle
// multiplier occupancy of EX and taken-branch flushes. Optional stall counter under HAZARD_PERF_EN.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IFID_Rs1,
  input  logic [4:0]  IFID_Rs2,
  input  logic        IFID_UsesRs1,
  input  logic        IFID_UsesRs2,
  input  logic [4:0]  IDEX_Rd,
  input  logic        IDEX_MemRead,
  input  logic        IDEX_IsMul,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        EXMEM_Bubble,
  output logic        MulBusy,
  output logic        MulDone,
  output logic [31:0] StallCycles
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  localparam logic [3:0] LAT  = 4'(MUL_LAT);

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mul_stall;
  logic       load_use;

  assign load_use = IDEX_MemRead && (IDEX_Rd != 5'd0) &&
                    ((IFID_UsesRs1 && (IDEX_Rd == IFID_Rs1)) ||
                     (IFID_UsesRs2 && (IDEX_Rd == IFID_Rs2)));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_stall    = 1'b0;
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Bubble  = 1'b0;
    EXMEM_Bubble = 1'b0;
    MulBusy      = 1'b0;
    MulDone      = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (IDEX_IsMul) begin
            if (LAT > 4'd1) begin
              mul_stall = 1'b1;
              cnt_d     = 4'd2;
              state_d   = MUL;
            end else begin
              MulDone = 1'b1;
            end
          end
        end
        default: begin
          if (cnt_q < LAT) begin
            mul_stall = 1'b1;
            cnt_d     = cnt_q + 4'd1;
          end else begin
            MulDone = 1'b1;
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
      endcase

      if (mul_stall) begin
        PCWrite      = 1'b0;
        IFID_Write   = 1'b0;
        IDEX_Write   = 1'b0;
        EXMEM_Bubble = 1'b1;
        MulBusy      = 1'b1;
      end else if (BranchTaken) begin
        // Flush wins over load-use: the dependent instruction is squashed anyway.
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
      end else if (load_use) begin
        PCWrite     = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign StallCycles = rst ? 32'd0 : stall_cnt_q;
`else
  assign StallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a driver applies directed vectors and queues
// hand-computed expectations, a monitor compares them on the falling edge.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, mr, mul, br;
  logic        pc_w, ifid_w, idex_w, flush, idex_b, exmem_b, busy, done;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Flag order: {PCWrite, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Bubble, EXMEM_Bubble, MulBusy, MulDone}
  localparam logic [7:0] F_DEF  = 8'b1110_0000;
  localparam logic [7:0] F_MUL  = 8'b0000_0110;
  localparam logic [7:0] F_DONE = 8'b1110_0001;
  localparam logic [7:0] F_LU   = 8'b0010_1000;
  localparam logic [7:0] F_BR   = 8'b1111_1000;

  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    sc_model = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LAT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .IFID_Rs1     (rs1),
    .IFID_Rs2     (rs2),
    .IFID_UsesRs1 (u1),
    .IFID_UsesRs2 (u2),
    .IDEX_Rd      (rd),
    .IDEX_MemRead (mr),
    .IDEX_IsMul   (mul),
    .BranchTaken  (br),
    .PCWrite      (pc_w),
    .IFID_Write   (ifid_w),
    .IDEX_Write   (idex_w),
    .IFID_Flush   (flush),
    .IDEX_Bubble  (idex_b),
    .EXMEM_Bubble (exmem_b),
    .MulBusy      (busy),
    .MulDone      (done),
    .StallCycles  (stall_cycles)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response for the monitor.
  task automatic vec(input string name, input logic r, input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                     input logic a_u1, input logic a_u2, input logic [4:0] a_rd, input logic a_mr,
                     input logic a_mul, input logic a_br, input logic [7:0] flags);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs1 = a_rs1; rs2 = a_rs2; u1 = a_u1; u2 = a_u2;
    rd = a_rd; mr = a_mr; mul = a_mul; br = a_br;
    e.flags = flags;
    e.sc    = (PERF && !r) ? 32'(sc_model) : 32'd0;
    exp_q.push_back(e);
    name_q.push_back(name);
    if (r) sc_model = 0;
    else if (!flags[7]) sc_model++;
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, " ctl"}, {24'd0, pc_w, ifid_w, idex_w, flush, idex_b, exmem_b, busy, done},
              {24'd0, e.flags});
        check({n, " stall_cnt"}, stall_cycles, e.sc);
      end
    end
  end

  initial begin : driver
    rst = 1'b1; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0; rd = '0; mr = 0; mul = 0; br = 0;

    vec("reset0",      1, 0, 0, 0, 0, 0, 0, 0, 0, F_DEF);
    vec("reset1",      1, 0, 0, 0, 0, 0, 0, 0, 0, F_DEF);
    vec("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, F_DEF);
    vec("lu_rs1",      0, 5, 0, 1, 0, 5, 1, 0, 0, F_LU);
    vec("lu_clear",    0, 5, 0, 1, 0, 5, 0, 0, 0, F_DEF);
    vec("lu_rd0",      0, 0, 0, 1, 0, 0, 1, 0, 0, F_DEF);
    vec("lu_rs2_nouse",0, 0, 7, 0, 0, 7, 1, 0, 0, F_DEF);
    vec("lu_rs2",      0, 0, 7, 0, 1, 7, 1, 0, 0, F_LU);
    vec("mul_c1",      0, 0, 0, 0, 0, 0, 0, 1, 0, F_MUL);
    vec("mul_c2",      0, 0, 0, 0, 0, 0, 0, 1, 0, F_MUL);
    vec("mul_done",    0, 0, 0, 0, 0, 0, 0, 1, 0, F_DONE);
    vec("b2b_a1",      0, 0, 0, 0, 0, 0, 0, 1, 0, F_MUL);
    vec("b2b_a2",      0, 0, 0, 0, 0, 0, 0, 1, 0, F_MUL);
    vec("b2b_adone",   0, 0, 0, 0, 0, 0, 0, 1, 0, F_DONE);
    vec("b2b_b1",      0, 0, 0, 0, 0, 0, 0, 1, 0, F_MUL);
    vec("b2b_b2",      0, 0, 0, 0, 0, 0, 0, 1, 0, F_MUL);
    vec("b2b_bdone",   0, 0, 0, 0, 0, 0, 0, 1, 0, F_DONE);
    vec("after_mul",   0, 0, 0, 0, 0, 0, 0, 0, 0, F_DEF);
    vec("br_over_lu",  0, 5, 0, 1, 0, 5, 1, 0, 1, F_BR);
    vec("br_only",     0, 0, 0, 0, 0, 0, 0, 0, 1, F_BR);
    vec("rmul_c1",     0, 0, 0, 0, 0, 0, 0, 1, 0, F_MUL);
    vec("rmul_c2",     0, 0, 0, 0, 0, 0, 0, 1, 0, F_MUL);
    vec("rst_in_mul",  1, 0, 0, 0, 0, 0, 0, 1, 0, F_DEF);
    vec("post_rst0",   0, 0, 0, 0, 0, 0, 0, 0, 0, F_DEF);
    vec("post_rst1",   0, 0, 0, 0, 0, 0, 0, 0, 0, F_DEF);
    vec("lu_post_rst", 0, 9, 0, 1, 0, 9, 1, 0, 0, F_LU);
    vec("final_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, F_DEF);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall sequencer for the 5-stage pipelined core with the multi-cycle multiplier. It sits beside the forwarding logic and drives the write-enable, bubble and flush controls of PC, IF/ID, ID/EX and EX/MEM. It covers three cases: load-use hazards the forwarding network cannot resolve, multiplier occupancy of EX for MUL_LAT cycles, and taken-branch flushes.

## Interface
- MUL_LAT, 3: cycles a multiply occupies EX (legal 1..15); 1 means never stall.
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- IFID_Rs1  input  5  rs1 of the instruction in ID.
- IFID_Rs2  input  5  rs2 of the instruction in ID.
- IFID_UsesRs1  input  1  ID instruction reads rs1.
- IFID_UsesRs2  input  1  ID instruction reads rs2.
- IDEX_Rd  input  5  rd of the instruction in EX.
- IDEX_MemRead  input  1  instruction in EX is a load.
- IDEX_IsMul  input  1  instruction in EX is a multiply.
- BranchTaken  input  1  branch in EX resolved taken.
- PCWrite  output  1  PC update enable.
- IFID_Write  output  1  IF/ID register enable.
- IDEX_Write  output  1  ID/EX register enable.
- IFID_Flush  output  1  clear IF/ID to NOP.
- IDEX_Bubble  output  1  load zeroed controls into ID/EX.
- EXMEM_Bubble  output  1  load zeroed controls into EX/MEM.
- MulBusy  output  1  multiply in EX, result not ready.
- MulDone  output  1  final multiply cycle; EX result valid this cycle.
- StallCycles  output  32  stall-cycle count (see Configuration).

## Operation
- FSM states: IDLE and MUL. A 4-bit counter cnt tracks the current multiply cycle.
- Default outputs: all *_Write=1; Flush, Bubble, MulBusy and MulDone=0.
- **IDLE with IDEX_IsMul and MUL_LAT>1**
  - Mul stall: PCWrite=IFID_Write=IDEX_Write=0, EXMEM_Bubble=1, MulBusy=1.
  - Next cnt=2, next state MUL.
- **IDLE with IDEX_IsMul and MUL_LAT==1**: MulDone=1, no stall.
- **MUL**
  - When cnt<MUL_LAT: mul stall outputs, and cnt increments.
  - When cnt==MUL_LAT: MulDone=1, default write enables, next state IDLE, cnt cleared.
- **Load-use**, evaluated only when there is no mul stall: IDEX_MemRead, IDEX_Rd!=0, and either (IFID_UsesRs1 and IDEX_Rd==IFID_Rs1) or (IFID_UsesRs2 and IDEX_Rd==IFID_Rs2).
  - Response: PCWrite=0, IFID_Write=0, IDEX_Write=1, IDEX_Bubble=1.
  - Lasts one cycle; the load then advances and the condition clears.
- **Taken branch**, evaluated only when there is no mul stall: IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFID_Write=1.
- Priority: mul stall > BranchTaken > load-use. The load-use result is discarded when flushing.
- A multiply in EX with BranchTaken set is illegal. BranchTaken is ignored for as long as the mul stall is active.
- Back-to-back multiplies: the IDLE cycle after MulDone sees the next multiply and restarts the sequence with no gap.

## Timing
- All control outputs are combinational from state and inputs, and valid in the same cycle as the inputs.
- A multiply spends exactly MUL_LAT cycles in EX, with MUL_LAT-1 stall cycles followed by 1 MulDone cycle.
- Load-use costs exactly 1 stall cycle. Branch flush costs 0 stall cycles and squashes 2 instructions (the IF/ID and ID/EX contents).
- **While rst=1**
  - Outputs are forced to defaults: PCWrite=IFID_Write=IDEX_Write=1, others 0, MulBusy=MulDone=0.
  - StallCycles reads 0.
- **rst asserted during MUL**
  - The next state is IDLE with cnt=0. The interrupted multiply produces no MulDone.
  - After reset the pipeline is assumed flushed externally.

## Configuration
- HAZARD_PERF_EN defined:
  - StallCycles is a 32-bit register, cleared by rst.
  - It increments on each cycle with PCWrite==0 (mul or load-use stall) and saturates at 32'hFFFFFFFF.
- HAZARD_PERF_EN undefined: StallCycles is tied to 0 and no counter is synthesized. Hazard behaviour is identical.

## Test plan
- IDEX_MemRead=1, IDEX_Rd=5, IFID_Rs1=5, IFID_UsesRs1=1 -> one cycle with PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle (IDEX_MemRead=0) all defaults.
- Load with IDEX_Rd=0, IFID_Rs1=0 and UsesRs1=1; also Rd=7, Rs2=7 with UsesRs2=0 -> no stall in either case.
- MUL_LAT=3, IDEX_IsMul=1 held 3 cycles -> cycles 1-2: MulBusy=1, EXMEM_Bubble=1, all writes 0; cycle 3: MulDone=1, writes 1.
- Two multiplies back-to-back, MUL_LAT=3 -> pattern stall,stall,done,stall,stall,done over 6 cycles; StallCycles=4 with HAZARD_PERF_EN.
- BranchTaken=1 with a simultaneous load-use match -> IFID_Flush=1, IDEX_Bubble=1, PCWrite=1, IFID_Write=1.
- rst=1 in multiply cycle 2, then IDEX_IsMul=0 -> after reset all defaults, MulDone never asserted, StallCycles=0.
